// File: rtl/regfile_write_arbiter_if.sv
// Requester handshakes, register-file write command and read-address hazard lines
// for regfile_write_arbiter.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              mode;
    logic [ADDR_W-1:0] WriteAddress;
    logic [DATA_W-1:0] WriteValue;
    logic [ADDR_W-1:0] ReadAddress1;
    logic [ADDR_W-1:0] ReadAddress2;
    logic              hazard1;
    logic              hazard2;
    logic [15:0]       a_count;
    logic [15:0]       b_count;

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
               ReadAddress1, ReadAddress2,
        output a_ready, b_ready, mode, WriteAddress, WriteValue,
               hazard1, hazard2, a_count, b_count
    );

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
               ReadAddress1, ReadAddress2,
        input  a_ready, b_ready, mode, WriteAddress, WriteValue,
               hazard1, hazard2, a_count, b_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two requesters.
// Optional macro REGWRITE_ZERO_GUARD_EN: accept writes to r0 but never issue them.
module regfile_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]        stateReg;
    logic [0:0]        stateNext;
    logic              lastReg;
    logic [ADDR_W-1:0] writeAddressReg;
    logic [DATA_W-1:0] writeValueReg;

    logic [1:0]        reqValid;
    logic [1:0]        grant;
    logic              transfer;
    logic              writeEn;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;
    logic [1:0][15:0]  countVec;

    assign reqValid = {bus.b_valid, bus.a_valid};

    // Contention goes to whoever was not granted last; nothing is granted in reset.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (reqValid == 2'b11) begin
                grant = lastReg ? 2'b01 : 2'b10;
            end else begin
                grant = reqValid;
            end
        end
    end

    assign transfer = |grant;
    assign selAddr  = grant[1] ? bus.b_addr : bus.a_addr;
    assign selData  = grant[1] ? bus.b_data : bus.a_data;

`ifdef REGWRITE_ZERO_GUARD_EN
    assign writeEn = transfer && (selAddr != '0);
`else
    assign writeEn = transfer;
`endif

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    stateNext = writeEn ? WRITE : IDLE;
            WRITE:   stateNext = writeEn ? WRITE : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg        <= IDLE;
            lastReg         <= 1'b1;
            writeAddressReg <= '0;
            writeValueReg   <= '0;
        end else begin
            stateReg <= stateNext;
            if (transfer) begin
                lastReg <= grant[1];
            end
            // Command registers hold their last value while no write is issued.
            if (writeEn) begin
                writeAddressReg <= selAddr;
                writeValueReg   <= selData;
            end
        end
    end

    // One free-running wrap-around acceptance counter per requester.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_count
            logic [15:0] countReg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    countReg <= '0;
                end else if (grant[gi]) begin
                    countReg <= countReg + 16'd1;
                end
            end
            assign countVec[gi] = countReg;
        end
    endgenerate

    assign bus.a_ready      = grant[0];
    assign bus.b_ready      = grant[1];
    assign bus.mode         = (stateReg == WRITE);
    assign bus.WriteAddress = writeAddressReg;
    assign bus.WriteValue   = writeValueReg;
    assign bus.hazard1      = bus.mode && (bus.ReadAddress1 == writeAddressReg);
    assign bus.hazard2      = bus.mode && (bus.ReadAddress2 == writeAddressReg);
    assign bus.a_count      = countVec[0];
    assign bus.b_count      = countVec[1];
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a transaction-level model.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    regfile_write_arbiter_if #(.DATA_W(16), .ADDR_W(5)) bus ();

    regfile_write_arbiter #(.DATA_W(16), .ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Transaction-level model: who won last, how many each side got, what the regfile sees.
    bit          mLast;
    logic [15:0] mCountA, mCountB;
    bit          mMode;
    logic [4:0]  mWA;
    logic [15:0] mWV;

    task automatic model_reset();
        mLast = 1'b1; mCountA = 16'd0; mCountB = 16'd0;
        mMode = 1'b0; mWA = 5'd0; mWV = 16'd0;
    endtask

    task automatic model_accept(input bit winB, input logic [4:0] addr, input logic [15:0] data);
        bit doWrite;
        mLast = winB;
        if (winB) mCountB = mCountB + 16'd1;
        else      mCountA = mCountA + 16'd1;
`ifdef REGWRITE_ZERO_GUARD_EN
        doWrite = (addr != 5'd0);
`else
        doWrite = 1'b1;
`endif
        mMode = doWrite;
        if (doWrite) begin
            mWA = addr;
            mWV = data;
        end
    endtask

    task automatic drive(input bit av, input logic [4:0] aa, input logic [15:0] ad,
                         input bit bv, input logic [4:0] ba, input logic [15:0] bd);
        bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
        bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 5'd3, 16'hAAAA, 1'b1, 5'd4, 16'hBBBB);
        #1;
        checks++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got a=%b b=%b expected 0 0", bus.a_ready, bus.b_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.mode !== 1'b0 || bus.WriteAddress !== 5'd0 || bus.WriteValue !== 16'd0) begin
            errors++;
            $display("FAIL reset_cmd: got mode=%b wa=%h wv=%h expected 0 0 0",
                     bus.mode, bus.WriteAddress, bus.WriteValue);
        end
        checks++;
        if (bus.a_count !== 16'd0 || bus.b_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: got a=%h b=%h expected 0 0", bus.a_count, bus.b_count);
        end
        apply_reset();
        $display("test_reset done");
    endtask

    task automatic test_single_a();
        apply_reset();
        @(negedge clk);
        drive(1'b1, 5'd5, 16'h1234, 1'b0, 5'd0, 16'd0);
        bus.ReadAddress1 = 5'd5;
        bus.ReadAddress2 = 5'd7;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got a=%b b=%b expected 1 0", bus.a_ready, bus.b_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.mode !== 1'b1 || bus.WriteAddress !== 5'd5 || bus.WriteValue !== 16'h1234) begin
            errors++;
            $display("FAIL single_cmd: got mode=%b wa=%h wv=%h expected 1 05 1234",
                     bus.mode, bus.WriteAddress, bus.WriteValue);
        end
        checks++;
        if (bus.hazard1 !== 1'b1 || bus.hazard2 !== 1'b0 || bus.a_count !== 16'd1) begin
            errors++;
            $display("FAIL single_hazard_count: got h1=%b h2=%b a_count=%h expected 1 0 0001",
                     bus.hazard1, bus.hazard2, bus.a_count);
        end
        @(negedge clk);
        drive(1'b0, 5'd5, 16'h1234, 1'b0, 5'd0, 16'd0);
        @(posedge clk); #1;
        checks++;
        if (bus.mode !== 1'b0 || bus.WriteAddress !== 5'd5 || bus.hazard1 !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got mode=%b wa=%h h1=%b expected 0 05 0",
                     bus.mode, bus.WriteAddress, bus.hazard1);
        end
        $display("test_single_a done");
    endtask

    task automatic test_alternate();
        logic [4:0] aA, aB;
        logic [15:0] dA, dB;
        apply_reset();
        aA = 5'd10; dA = 16'hA000; aB = 5'd20; dB = 16'hB000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b1, aA, dA, 1'b1, aB, dB);
            #1;
            checks++;
            if (bus.a_ready !== ((k % 2) == 0) || bus.b_ready !== ((k % 2) == 1)) begin
                errors++;
                $display("FAIL alt_grant%0d: got a=%b b=%b expected a=%b",
                         k, bus.a_ready, bus.b_ready, (k % 2) == 0);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.mode !== 1'b1 || bus.WriteAddress !== (((k % 2) == 0) ? aA : aB)) begin
                errors++;
                $display("FAIL alt_cmd%0d: got mode=%b wa=%h expected 1 %h",
                         k, bus.mode, bus.WriteAddress, ((k % 2) == 0) ? aA : aB);
            end
            if ((k % 2) == 0) begin aA = aA + 5'd1; dA = dA + 16'd1; end
            else              begin aB = aB + 5'd1; dB = dB + 16'd1; end
        end
        checks++;
        if (bus.a_count !== 16'd2 || bus.b_count !== 16'd2) begin
            errors++;
            $display("FAIL alt_counts: got a=%h b=%h expected 2 2", bus.a_count, bus.b_count);
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0);
        $display("test_alternate done");
    endtask

    task automatic test_fairness();
        apply_reset();
        @(negedge clk);
        drive(1'b0, 5'd1, 16'h0101, 1'b1, 5'd2, 16'h0202);
        #1;
        checks++;
        if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
            errors++;
            $display("FAIL fair_b_only: got a=%b b=%b expected 0 1", bus.a_ready, bus.b_ready);
        end
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 5'd1, 16'h0101, 1'b1, 5'd3, 16'h0303);
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL fair_both_after_b: got a=%b b=%b expected 1 0", bus.a_ready, bus.b_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.mode !== 1'b1 || bus.WriteAddress !== 5'd1 || bus.WriteValue !== 16'h0101) begin
            errors++;
            $display("FAIL fair_cmd: got mode=%b wa=%h wv=%h expected 1 01 0101",
                     bus.mode, bus.WriteAddress, bus.WriteValue);
        end
        @(negedge clk);
        drive(1'b1, 5'd4, 16'h0404, 1'b1, 5'd3, 16'h0303);
        #1;
        checks++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b1) begin
            errors++;
            $display("FAIL fair_both_after_a: got a=%b b=%b expected 0 1", bus.a_ready, bus.b_ready);
        end
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0);
        $display("test_fairness done");
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        @(negedge clk);
        drive(1'b1, 5'd6, 16'h6666, 1'b1, 5'd7, 16'h7777);
        @(posedge clk); #1;
        checks++;
        if (bus.mode !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got mode=%b expected 1", bus.mode);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 5'd8, 16'h8888, 1'b1, 5'd7, 16'h7777);
        #1;
        checks++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready: got a=%b b=%b expected 0 0", bus.a_ready, bus.b_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.mode !== 1'b0 || bus.a_count !== 16'd0 || bus.b_count !== 16'd0
            || bus.WriteAddress !== 5'd0 || bus.WriteValue !== 16'd0) begin
            errors++;
            $display("FAIL midrst_state: got mode=%b a=%h b=%h wa=%h wv=%h expected all 0",
                     bus.mode, bus.a_count, bus.b_count, bus.WriteAddress, bus.WriteValue);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_first: got a=%b b=%b expected 1 0", bus.a_ready, bus.b_ready);
        end
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0);
        $display("test_reset_mid_write done");
    endtask

    task automatic test_zero_addr();
        apply_reset();
        @(negedge clk);
        drive(1'b1, 5'd0, 16'hFFFF, 1'b0, 5'd0, 16'd0);
        bus.ReadAddress1 = 5'd0;
        bus.ReadAddress2 = 5'd9;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready: got a=%b expected 1", bus.a_ready);
        end
        @(posedge clk); #1;
`ifdef REGWRITE_ZERO_GUARD_EN
        checks++;
        if (bus.mode !== 1'b0 || bus.hazard1 !== 1'b0 || bus.a_count !== 16'd1) begin
            errors++;
            $display("FAIL zero_guard: got mode=%b h1=%b a_count=%h expected 0 0 0001",
                     bus.mode, bus.hazard1, bus.a_count);
        end
`else
        checks++;
        if (bus.mode !== 1'b1 || bus.WriteAddress !== 5'd0 || bus.WriteValue !== 16'hFFFF
            || bus.hazard1 !== 1'b1 || bus.a_count !== 16'd1) begin
            errors++;
            $display("FAIL zero_write: got mode=%b wa=%h wv=%h h1=%b a_count=%h expected 1 00 ffff 1 0001",
                     bus.mode, bus.WriteAddress, bus.WriteValue, bus.hazard1, bus.a_count);
        end
`endif
        @(negedge clk);
        drive(1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0);
        $display("test_zero_addr done");
    endtask

    task automatic test_random();
        bit pA, pB, expA, expB;
        logic [4:0] aA, aB;
        logic [15:0] dA, dB;
        apply_reset();
        pA = 1'b0; pB = 1'b0;
        aA = 5'd0; aB = 5'd0; dA = 16'd0; dB = 16'd0;
        for (int i = 0; i < 400; i++) begin
            if (!pA && $urandom_range(0, 2) != 0) begin
                pA = 1'b1; aA = 5'($urandom); dA = 16'($urandom);
            end
            if (!pB && $urandom_range(0, 2) != 0) begin
                pB = 1'b1; aB = 5'($urandom); dB = 16'($urandom);
            end
            @(negedge clk);
            drive(pA, aA, dA, pB, aB, dB);
            bus.ReadAddress1 = ($urandom_range(0, 1) == 0) ? mWA : 5'($urandom);
            bus.ReadAddress2 = ($urandom_range(0, 1) == 0) ? mWA : 5'($urandom);
            expA = pA && (!pB || mLast);
            expB = pB && (!pA || !mLast);
            #1;
            checks++;
            if (bus.a_ready !== expA || bus.b_ready !== expB) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got a=%b b=%b expected a=%b b=%b",
                         i, bus.a_ready, bus.b_ready, expA, expB);
            end
            @(posedge clk); #1;
            if (expA) begin
                model_accept(1'b0, aA, dA); pA = 1'b0;
            end else if (expB) begin
                model_accept(1'b1, aB, dB); pB = 1'b0;
            end else begin
                mMode = 1'b0;
            end
            checks++;
            if (bus.mode !== mMode || bus.WriteAddress !== mWA || bus.WriteValue !== mWV) begin
                errors++;
                $display("FAIL rand_cmd[%0d]: got mode=%b wa=%h wv=%h expected %b %h %h",
                         i, bus.mode, bus.WriteAddress, bus.WriteValue, mMode, mWA, mWV);
            end
            checks++;
            if (bus.a_count !== mCountA || bus.b_count !== mCountB
                || bus.hazard1 !== (mMode && bus.ReadAddress1 == mWA)
                || bus.hazard2 !== (mMode && bus.ReadAddress2 == mWA)) begin
                errors++;
                $display("FAIL rand_cnt_haz[%0d]: got a=%h b=%h h1=%b h2=%b expected %h %h %b %b",
                         i, bus.a_count, bus.b_count, bus.hazard1, bus.hazard2, mCountA, mCountB,
                         mMode && bus.ReadAddress1 == mWA, mMode && bus.ReadAddress2 == mWA);
            end
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0);
        $display("test_random done");
    endtask

    task automatic test_wrap();
        apply_reset();
        drive(1'b1, 5'd3, 16'h0003, 1'b0, 5'd0, 16'd0);
        repeat (65535) @(posedge clk);
        #1;
        checks++;
        if (bus.a_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload: got a_count=%h expected ffff", bus.a_count);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.a_count !== 16'h0000 || bus.mode !== 1'b1) begin
            errors++;
            $display("FAIL wrap_rollover: got a_count=%h mode=%b expected 0000 1", bus.a_count, bus.mode);
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0);
        $display("test_wrap done");
    endtask

    initial begin
        drive(1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0);
        bus.ReadAddress1 = 5'd0;
        bus.ReadAddress2 = 5'd0;
        model_reset();
        test_reset();
        test_single_a();
        test_alternate();
        test_fairness();
        test_reset_mid_write();
        test_zero_addr();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
